// File: rtl/tt_ecp5_project_sel.sv
// tt_ecp5_project_sel
//   Shares one TT pin set between NUM_PROJ user designs. It owns the
//   active-project select, the per-project ena/rst_n lines and a global
//   uio output-enable gate.
//
//   Switching a project runs this sequence:
//     1. tristate uio and park every design (GUARD);
//     2. hold the newly selected design in reset (RESET);
//     3. release it (RUN).
//
//   Ports:
//     clk, rst        clock; synchronous active-high controller reset
//     sel_req_valid   switch/restart request handshake (valid/ready)
//     sel_req_ready
//     sel_req_id      requested project id
//     sel_err         1-cycle pulse when an accepted id is out of range
//     ext_rst_n       synchronised board reset button, active-low
//     out_sel         active project id, drives the pin mux
//     proj_ena        per-project enable
//     proj_rst_n      per-project reset, active-low
//     uio_oe_en       global uio output-enable gate (0 = all tristated)
//     busy            switch/reset sequence in progress
//
//   Every output is registered except sel_req_ready, which decodes the
//   state register only.
module tt_ecp5_project_sel #(
    parameter int NUM_PROJ     = 4,
    parameter int SEL_W        = 2,
    parameter int DEFAULT_ID   = 0,
    parameter int RST_CYCLES   = 16,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sel_req_valid,
    input  logic [SEL_W-1:0]    sel_req_id,
    output logic                sel_req_ready,
    output logic                sel_err,
    input  logic                ext_rst_n,
    output logic [SEL_W-1:0]    out_sel,
    output logic [NUM_PROJ-1:0] proj_ena,
    output logic [NUM_PROJ-1:0] proj_rst_n,
    output logic                uio_oe_en,
    output logic                busy
);

    localparam int MAX_CYC = (RST_CYCLES > GUARD_CYCLES) ? RST_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [SEL_W-1:0] DEF_ID     = SEL_W'(DEFAULT_ID);

    typedef enum logic [1:0] {
        ST_GUARD = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // One-hot decode of a project id; ids outside the range decode to zero.
    function automatic logic [NUM_PROJ-1:0] onehot(input logic [SEL_W-1:0] id);
        logic [NUM_PROJ-1:0] o;
        o = '0;
        for (int i = 0; i < NUM_PROJ; i++) begin
            o[i] = (id == SEL_W'(i));
        end
        return o;
    endfunction

    state_t               state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [SEL_W-1:0]     out_sel_r, out_sel_s;
    logic [SEL_W-1:0]     pending_r, pending_s;
    logic                 err_r, err_s;
    logic [NUM_PROJ-1:0]  ena_r, ena_s;
    logic [NUM_PROJ-1:0]  rst_n_r, rst_n_s;
    logic                 oe_r, oe_s;
    logic                 busy_r, busy_s;

    // Next-state logic. The output image is decoded from the next state,
    // so the outputs can be registered without adding a cycle of latency.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        out_sel_s = out_sel_r;
        pending_s = pending_r;
        err_s     = 1'b0;
        case (state_r)
            ST_RUN: begin
                // An accepted request takes priority over the reset button.
                if (sel_req_valid) begin
                    if (int'(sel_req_id) >= NUM_PROJ) begin
                        err_s = 1'b1;
                    end else begin
                        pending_s = sel_req_id;
                        state_s   = ST_GUARD;
                        cnt_s     = GUARD_LOAD;
                    end
                end else if (!ext_rst_n) begin
                    state_s = ST_RESET;
                    cnt_s   = RST_LOAD;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_GUARD: begin
                if (cnt_r == '0) begin
                    out_sel_s = pending_r;
                    state_s   = ST_RESET;
                    cnt_s     = RST_LOAD;
                end else begin
                    cnt_s = cnt_r - 1'b1;
                end
            end
            ST_RESET: begin
                // Reload the counter while the button is held, so the reset
                // stretches to the full length after the button is released.
                if (!ext_rst_n) begin
                    cnt_s = RST_LOAD;
                end else if (cnt_r == '0) begin
                    state_s = ST_RUN;
                end else begin
                    cnt_s = cnt_r - 1'b1;
                end
            end
            default: begin
                state_s = ST_RESET;
                cnt_s   = RST_LOAD;
            end
        endcase
    end

    // Output image for the state that is about to be entered.
    always_comb begin
        ena_s   = '0;
        rst_n_s = '0;
        oe_s    = 1'b0;
        busy_s  = 1'b1;
        case (state_s)
            ST_RUN: begin
                // Non-active designs stay in reset while one project runs.
                ena_s   = onehot(out_sel_s);
                rst_n_s = onehot(out_sel_s);
                oe_s    = 1'b1;
                busy_s  = 1'b0;
            end
            ST_RESET: begin
                ena_s = onehot(out_sel_s);
            end
            ST_GUARD: begin
                ena_s = '0;
            end
            default: begin
                ena_s = '0;
            end
        endcase
    end

    // State, counter, select and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_RESET;
            cnt_r     <= RST_LOAD;
            out_sel_r <= DEF_ID;
            pending_r <= DEF_ID;
            err_r     <= 1'b0;
            ena_r     <= onehot(DEF_ID);
            rst_n_r   <= '0;
            oe_r      <= 1'b0;
            busy_r    <= 1'b1;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            out_sel_r <= out_sel_s;
            pending_r <= pending_s;
            err_r     <= err_s;
            ena_r     <= ena_s;
            rst_n_r   <= rst_n_s;
            oe_r      <= oe_s;
            busy_r    <= busy_s;
        end
    end

    assign sel_req_ready = (state_r == ST_RUN);
    assign sel_err       = err_r;
    assign out_sel       = out_sel_r;
    assign proj_ena      = ena_r;
    assign proj_rst_n    = rst_n_r;
    assign uio_oe_en     = oe_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_tt_ecp5_project_sel.sv
// Bench for tt_ecp5_project_sel (NUM_PROJ=4, SEL_W=3, 16-cycle reset,
// 2-cycle guard). Each table row holds its inputs steady for a number of
// cycles. After every clock edge the full output image is compared against
// the row's expected image.
module tb_tt_ecp5_project_sel;

    localparam int NP = 4;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          sel_req_valid;
    logic [SW-1:0] sel_req_id;
    logic          sel_req_ready;
    logic          sel_err;
    logic          ext_rst_n;
    logic [SW-1:0] out_sel;
    logic [NP-1:0] proj_ena;
    logic [NP-1:0] proj_rst_n;
    logic          uio_oe_en;
    logic          busy;

    tt_ecp5_project_sel #(
        .NUM_PROJ(NP), .SEL_W(SW), .DEFAULT_ID(0), .RST_CYCLES(16), .GUARD_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .sel_req_valid(sel_req_valid), .sel_req_id(sel_req_id),
        .sel_req_ready(sel_req_ready), .sel_err(sel_err), .ext_rst_n(ext_rst_n),
        .out_sel(out_sel), .proj_ena(proj_ena), .proj_rst_n(proj_rst_n),
        .uio_oe_en(uio_oe_en), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          valid;
        logic [SW-1:0] id;
        logic          ext;
        int            reps;
        logic [14:0]   exp;   // {out_sel, ena, rst_n, oe, busy, ready, err}
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passed = 0;

    task automatic add(input logic r, input logic v, input logic [SW-1:0] id,
                       input logic x, input int reps, input logic [SW-1:0] os,
                       input logic [NP-1:0] en, input logic [NP-1:0] rn,
                       input logic oe, input logic bz, input logic rdy, input logic er);
        vec_t t;
        t.rst = r; t.valid = v; t.id = id; t.ext = x; t.reps = reps;
        t.exp = {os, en, rn, oe, bz, rdy, er};
        vecs.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] image();
        return {out_sel, proj_ena, proj_rst_n, uio_oe_en, busy, sel_req_ready, sel_err};
    endfunction

    initial begin
        int n;
        rst = 1'b1; sel_req_valid = 1'b0; sel_req_id = '0; ext_rst_n = 1'b1;

        // reset, then 16 cycles in reset, then RUN id0
        add(1,0,0,1, 3, 0,4'b0001,4'b0000,0,1,0,0);
        add(0,0,0,1,15, 0,4'b0001,4'b0000,0,1,0,0);
        add(0,0,0,1, 3, 0,4'b0001,4'b0001,1,0,1,0);
        // rst mid-GUARD of 0->3: id3 never enabled
        add(0,1,3,1, 1, 0,4'b0000,4'b0000,0,1,0,0);
        add(1,0,0,1, 1, 0,4'b0001,4'b0000,0,1,0,0);
        add(0,0,0,1,15, 0,4'b0001,4'b0000,0,1,0,0);
        add(0,0,0,1, 2, 0,4'b0001,4'b0001,1,0,1,0);
        // switch 0->2: 2 guard, 16 reset, run
        add(0,1,2,1, 1, 0,4'b0000,4'b0000,0,1,0,0);
        add(0,0,0,1, 1, 0,4'b0000,4'b0000,0,1,0,0);
        add(0,0,0,1,16, 2,4'b0100,4'b0000,0,1,0,0);
        add(0,0,0,1, 2, 2,4'b0100,4'b0100,1,0,1,0);
        // out-of-range ids 5, 4 (boundary), 7 together with ext_rst_n low
        add(0,1,5,1, 1, 2,4'b0100,4'b0100,1,0,1,1);
        add(0,0,0,1, 1, 2,4'b0100,4'b0100,1,0,1,0);
        add(0,1,4,1, 1, 2,4'b0100,4'b0100,1,0,1,1);
        add(0,0,0,1, 1, 2,4'b0100,4'b0100,1,0,1,0);
        add(0,1,7,0, 1, 2,4'b0100,4'b0100,1,0,1,1);
        add(0,0,0,1, 2, 2,4'b0100,4'b0100,1,0,1,0);
        // switch 2->1
        add(0,1,1,1, 1, 2,4'b0000,4'b0000,0,1,0,0);
        add(0,0,0,1, 1, 2,4'b0000,4'b0000,0,1,0,0);
        add(0,0,0,1,16, 1,4'b0010,4'b0000,0,1,0,0);
        add(0,0,0,1, 2, 1,4'b0010,4'b0010,1,0,1,0);
        // button held 40 cycles, then 16 more cycles of reset after release
        add(0,0,0,0,40, 1,4'b0010,4'b0000,0,1,0,0);
        add(0,0,0,1,15, 1,4'b0010,4'b0000,0,1,0,0);
        add(0,0,0,1, 2, 1,4'b0010,4'b0010,1,0,1,0);
        // restart id1 (id == out_sel): 18 busy cycles
        add(0,1,1,1, 1, 1,4'b0000,4'b0000,0,1,0,0);
        add(0,0,0,1, 1, 1,4'b0000,4'b0000,0,1,0,0);
        add(0,0,0,1,16, 1,4'b0010,4'b0000,0,1,0,0);
        add(0,0,0,1, 2, 1,4'b0010,4'b0010,1,0,1,0);
        // request and button in the same cycle: request wins, button ignored in GUARD
        add(0,1,3,0, 1, 1,4'b0000,4'b0000,0,1,0,0);
        add(0,0,0,0, 1, 1,4'b0000,4'b0000,0,1,0,0);
        add(0,0,0,1,16, 3,4'b1000,4'b0000,0,1,0,0);
        add(0,0,0,1, 2, 3,4'b1000,4'b1000,1,0,1,0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; sel_req_valid = vecs[i].valid;
            sel_req_id = vecs[i].id; ext_rst_n = vecs[i].ext;
            for (int k = 0; k < vecs[i].reps; k++) begin
                step();
                check($sformatf("row%0d.cyc%0d", i, k), image(), vecs[i].exp);
            end
        end

        // Latency: RUN is reached on the 19th edge after the accepting edge is counted.
        rst = 1'b0; ext_rst_n = 1'b1; sel_req_valid = 1'b1; sel_req_id = 3'd0;
        check("ready_in_run", {14'd0, sel_req_ready}, 15'd1);
        step();
        sel_req_valid = 1'b0;
        n = 1;
        while (!uio_oe_en && n < 100) begin
            step();
            n++;
        end
        check("switch_latency", 15'(n), 15'd19);
        check("after_switch", image(), {3'd0, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0});

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
